// File: rtl/chunk_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : chunk_serial_subtractor
// Description : Digit-serial subtractor computing DIFF = A - B - Bin over
//               WIDTH bits, CHUNK bits per clock, least-significant chunk
//               first. The borrow between chunks is held in a flop, so one
//               operation takes NCH = WIDTH/CHUNK RUN cycles plus one DONE
//               cycle. A start/busy/done handshake connects it to a
//               controlling FSM.
//
// Ports       :
//   clk      in   1      clock, all state on the rising edge
//   rst_n    in   1      asynchronous active-low reset
//   i_start  in   1      operation request, sampled only while idle
//   i_a      in   WIDTH  minuend, captured on the accepting edge
//   i_b      in   WIDTH  subtrahend, captured on the accepting edge
//   i_bin    in   1      borrow-in, captured on the accepting edge
//   o_busy   out  1      high while chunks are being processed
//   o_done   out  1      one-cycle pulse, result outputs just updated
//   o_diff   out  WIDTH  A - B - Bin modulo 2^WIDTH
//   o_bout   out  1      borrow-out, 1 iff unsigned A < B + Bin
//   o_zero   out  1      o_diff == 0
//   o_ovf    out  1      signed (two's-complement) overflow
//
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout,
    output logic             o_zero,
    output logic             o_ovf
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int NCH  = WIDTH / CHUNK;
    // Keep the chunk index at least one bit wide so NCH == 1 still elaborates.
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;       // captured minuend
    logic [WIDTH-1:0] r_b;       // captured subtrahend
    logic [WIDTH-1:0] r_work;    // partially assembled difference
    logic             r_brw;     // borrow into the chunk at r_idx
    logic [IDXW-1:0]  r_idx;     // chunk currently being processed
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;
    logic             r_ovf;

    // ------------------------------------------------------------------------
    // Chunk datapath
    // ------------------------------------------------------------------------
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_sub;        // {borrow_out, chunk_difference}
    logic [WIDTH-1:0] w_work_next;  // working value with current chunk merged
    logic             w_last;

    // Operand chunk multiplexer driven by the chunk index.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_chunk = r_a[i*CHUNK +: CHUNK];
                w_b_chunk = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    // Zero-extended by one bit: the extra MSB of the result is 1 exactly when
    // the chunk subtraction wrapped, i.e. it is the borrow to the next chunk.
    assign w_sub = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - {{CHUNK{1'b0}}, r_brw};

    // Only the chunk at r_idx is replaced; the rest of the working value holds.
    // The merged value feeds the result registers directly so the final chunk
    // lands in o_diff on the same edge that enters DONE.
    for (genvar g = 0; g < NCH; g++) begin : g_chunk
        localparam logic [IDXW-1:0] CHUNK_IDX = IDXW'(g);
        assign w_work_next[g*CHUNK +: CHUNK] =
            (r_idx == CHUNK_IDX) ? w_sub[CHUNK-1:0] : r_work[g*CHUNK +: CHUNK];
    end

    assign w_last = (r_idx == LAST_IDX);

    // ------------------------------------------------------------------------
    // Control FSM and registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_brw   <= 1'b0;
            r_idx   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_brw   <= i_bin;
                        r_work  <= '0;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_work <= w_work_next;
                    r_brw  <= w_sub[CHUNK];
                    r_idx  <= r_idx + 1'b1;
                    if (w_last) begin
                        r_diff  <= w_work_next;
                        r_bout  <= w_sub[CHUNK];
                        r_zero  <= (w_work_next == '0);
                        // Overflow only when operand signs differ and the
                        // result sign departs from the minuend's sign.
                        r_ovf   <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) &
                                   (w_work_next[WIDTH-1] ^ r_a[WIDTH-1]);
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_busy = (r_state == ST_RUN);
    assign o_done = (r_state == ST_DONE);
    assign o_diff = r_diff;
    assign o_bout = r_bout;
    assign o_zero = r_zero;
    assign o_ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunk_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunk_serial_subtractor
// Description : Self-checking bench for chunk_serial_subtractor. One instance
//               at WIDTH=16/CHUNK=4 (four chunk cycles) and one at
//               WIDTH=16/CHUNK=16 (single chunk cycle). Expected results come
//               from plain 17-bit arithmetic on the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunk_serial_subtractor;

    localparam int WIDTH = 16;
    localparam int NCH4  = 4;

    logic             clk;
    logic             rst_n;

    // Four-chunk instance
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_bin;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_bout;
    logic             o_zero;
    logic             o_ovf;

    // Single-chunk instance
    logic             s1_start;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_bin;
    logic             s1_busy;
    logic             s1_done;
    logic [WIDTH-1:0] s1_diff;
    logic             s1_bout;
    logic             s1_zero;
    logic             s1_ovf;

    int n_pass;
    int n_total;

    // Result the four-chunk instance should currently be presenting.
    logic [WIDTH-1:0] prev_diff;

    chunk_serial_subtractor #(.WIDTH(WIDTH), .CHUNK(4)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(i_start),
        .i_a    (i_a),
        .i_b    (i_b),
        .i_bin  (i_bin),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_diff (o_diff),
        .o_bout (o_bout),
        .o_zero (o_zero),
        .o_ovf  (o_ovf)
    );

    chunk_serial_subtractor #(.WIDTH(WIDTH), .CHUNK(16)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(s1_start),
        .i_a    (s1_a),
        .i_b    (s1_b),
        .i_bin  (s1_bin),
        .o_busy (s1_busy),
        .o_done (s1_done),
        .o_diff (s1_diff),
        .o_bout (s1_bout),
        .o_zero (s1_zero),
        .o_ovf  (s1_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: {ovf, zero, bout, diff} from whole-word arithmetic.
    function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mbin);
        logic [16:0] full;
        logic [15:0] d;
        logic        ov;
        full = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
        d    = full[15:0];
        ov   = (ma[15] != mb[15]) && (d[15] != ma[15]);
        return {ov, (d == 16'd0), full[16], d};
    endfunction

    // One operation on the four-chunk instance, checking handshake timing,
    // result hold during RUN, and the final result. Optionally pulses start
    // with different operands in the middle of RUN.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tbin, input bit pulse_mid, input string name);
        logic [18:0] exp;
        int          cycles;
        bit          seen;
        exp = model(ta, tb_v, tbin);
        @(negedge clk);
        i_start = 1'b1; i_a = ta; i_b = tb_v; i_bin = tbin;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_a = 16'($urandom); i_b = 16'($urandom); i_bin = 1'($urandom);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 20) begin
            if (o_done) begin
                seen = 1'b1;
            end else begin
                n_total++;
                if (o_busy !== 1'b1 || o_diff !== prev_diff) begin
                    $display("FAIL %s run_hold cyc=%0d: busy=%b diff=%h, required busy=1 diff=%h",
                             name, cycles, o_busy, o_diff, prev_diff);
                end else n_pass++;
                if (pulse_mid && cycles == 1) begin
                    i_start = 1'b1;
                    i_a = ~ta; i_b = ta; i_bin = ~tbin;
                end else begin
                    i_start = 1'b0;
                end
                @(posedge clk); #1;
                cycles++;
            end
        end
        i_start = 1'b0;
        n_total++;
        if (!seen || cycles != NCH4) begin
            $display("FAIL %s latency: done after %0d edges (seen=%b), required %0d",
                     name, cycles, seen, NCH4);
        end else n_pass++;
        n_total++;
        if ({o_ovf, o_zero, o_bout, o_diff} !== exp || o_busy !== 1'b0) begin
            $display("FAIL %s result: ovf/zero/bout/diff=%b/%b/%b/%h busy=%b, required %b/%b/%b/%h busy=0",
                     name, o_ovf, o_zero, o_bout, o_diff, o_busy,
                     exp[18], exp[17], exp[16], exp[15:0]);
        end else n_pass++;
        prev_diff = exp[15:0];
        @(posedge clk); #1;
        n_total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_diff !== exp[15:0]) begin
            $display("FAIL %s after_done: done=%b busy=%b diff=%h, required done=0 busy=0 diff=%h",
                     name, o_done, o_busy, o_diff, exp[15:0]);
        end else n_pass++;
    endtask

    task automatic test_reset();
        i_start = 1'b0; i_a = '0; i_b = '0; i_bin = 1'b0;
        s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_bin = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({o_busy, o_done, o_diff, o_bout, o_zero, o_ovf} !== 21'd0) begin
            $display("FAIL reset_dut4: busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b, required all 0",
                     o_busy, o_done, o_diff, o_bout, o_zero, o_ovf);
        end else n_pass++;
        n_total++;
        if ({s1_busy, s1_done, s1_diff, s1_bout, s1_zero, s1_ovf} !== 21'd0) begin
            $display("FAIL reset_dut1: busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b, required all 0",
                     s1_busy, s1_done, s1_diff, s1_bout, s1_zero, s1_ovf);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        prev_diff = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h0234, 1'b0, 1'b0, "plain");
        run_op(16'h0000, 16'h0001, 1'b0, 1'b0, "underflow");
        run_op(16'h1000, 16'h0001, 1'b0, 1'b0, "ripple3");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b0, "signed_ovf");
        run_op(16'h0005, 16'h0004, 1'b1, 1'b0, "zero_bin");
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, "ovf_pos");
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, "bin_only");
    endtask

    task automatic test_start_ignored();
        run_op(16'hA5C3, 16'h1F0E, 1'b1, 1'b1, "mid_start");
        // The mid-RUN request must not have been queued.
        repeat (3) begin
            @(posedge clk); #1;
            n_total++;
            if (o_busy !== 1'b0 || o_done !== 1'b0) begin
                $display("FAIL no_queue: busy=%b done=%b, required 0/0", o_busy, o_done);
            end else n_pass++;
        end
    endtask

    task automatic test_midrun_reset();
        @(negedge clk);
        i_start = 1'b1; i_a = 16'h4321; i_b = 16'h1234; i_bin = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Two chunks processed; chunk 2 is next.
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({o_busy, o_done, o_diff, o_bout, o_zero, o_ovf} !== 21'd0) begin
            $display("FAIL midrun_reset: busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b, required all 0",
                     o_busy, o_done, o_diff, o_bout, o_zero, o_ovf);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        prev_diff = '0;
        repeat (6) begin
            @(posedge clk); #1;
            n_total++;
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                $display("FAIL abort_no_done: done=%b busy=%b, required 0/0", o_done, o_busy);
            end else n_pass++;
        end
        run_op(16'h4321, 16'h1234, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] ra;
        logic [15:0] rb;
        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 5))
                0: ra = 16'h0000;
                1: rb = 16'hFFFF;
                2: rb = ra;
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom), 1'($urandom_range(0, 3) == 0), "random");
        end
    endtask

    task automatic test_nch1();
        logic [18:0] exp;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbin;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                ra = 16'hFFFF; rb = 16'hFFFF; rbin = 1'b1;
            end else begin
                ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
            end
            exp = model(ra, rb, rbin);
            @(negedge clk);
            s1_start = 1'b1; s1_a = ra; s1_b = rb; s1_bin = rbin;
            @(posedge clk); #1;
            s1_start = 1'b0; s1_a = ~ra; s1_b = ~rb;
            n_total++;
            if (s1_busy !== 1'b1 || s1_done !== 1'b0) begin
                $display("FAIL nch1_run: busy=%b done=%b, required 1/0", s1_busy, s1_done);
            end else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if (s1_done !== 1'b1 || {s1_ovf, s1_zero, s1_bout, s1_diff} !== exp) begin
                $display("FAIL nch1_result: done=%b ovf/zero/bout/diff=%b/%b/%b/%h, required done=1 %b/%b/%b/%h",
                         s1_done, s1_ovf, s1_zero, s1_bout, s1_diff,
                         exp[18], exp[17], exp[16], exp[15:0]);
            end else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if (s1_done !== 1'b0 || s1_busy !== 1'b0) begin
                $display("FAIL nch1_idle: done=%b busy=%b, required 0/0", s1_done, s1_busy);
            end else n_pass++;
        end
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        prev_diff = '0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_midrun_reset();
        test_random();
        test_nch1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chunk_serial_subtractor.md
Name: chunk_serial_subtractor

Overview:
- Digit-serial unsigned/two's-complement subtractor; computes DIFF = A - B - Bin over WIDTH bits, CHUNK bits per clock, LSB chunk first.
- Borrow carried between chunks in a flop, making this the subtracting counterpart of the team's carry-based adder cells.
- Sits beside the adder datapath where area matters more than latency; start/busy/done handshake to a controlling FSM.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per clock; NCH = WIDTH/CHUNK chunk cycles per operation (1 <= NCH).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results valid and updated.
- diff  output  WIDTH  registered result A - B - Bin mod 2^WIDTH.
- bout  output  1  borrow-out (1 iff unsigned A < B + Bin).
- zero  output  1  diff == 0.
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- Reset (rst_n low, immediate, async): state IDLE; busy, done, diff, bout, zero, ovf all 0; internal operand, working and chunk-index registers 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge -> latch a, b into operand regs, borrow flop <= bin, idx <= 0, state -> RUN. start=0 -> stay.
- RUN (busy=1): each edge processes chunk idx: {brw_next, dchunk} = a_chunk - b_chunk - borrow, computed CHUNK+1 bits wide; dchunk written to working reg bits [idx*CHUNK +: CHUNK]; borrow <= brw_next; idx <= idx+1.
- On the edge processing idx = NCH-1: state -> DONE; diff <= complete working value including the final chunk; bout <= final borrow; zero and ovf derived from that complete value, all on the same edge.
- DONE: done=1 for exactly one cycle, busy=0; next edge -> IDLE unconditionally.
- Latency: start accepted at edge T -> done high in the cycle after edge T+NCH; throughput one op per NCH+2 cycles.
- diff/bout/zero/ovf hold the previous result throughout RUN and update only on the DONE-entry edge; held until the next completion.
- start while busy or done: ignored, no queueing; changes to a/b/bin after acceptance do not affect the result.
- Reset mid-RUN: operation aborted, no done pulse, outputs cleared to 0.
- NCH=1: single RUN cycle, then DONE.
- Borrow ripple across chunks: a chunk result of all ones with borrow out must propagate into the next chunk on the following edge.

Test Plan:
- WIDTH=16/CHUNK=4: a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, zero=0, ovf=0; busy high 4 cycles; done 4 edges after accept.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0; a=0x1000, b=0x0001 -> diff=0x0FFF (borrow ripples through 3 chunks).
- a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, bout=0; a=0x0005, b=0x0004, bin=1 -> diff=0x0000, zero=1, bout=0.
- start pulsed mid-RUN with different operands -> ignored, first result unchanged; prior diff value stable during RUN until the DONE edge.
- rst_n low at RUN idx=2 -> all outputs 0 immediately, no done; next start completes normally.
- Re-elaborate CHUNK=16 (NCH=1): a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1, done one edge after accept.
